// File: rtl/approx_adder_err_eval_pkg.sv
// Shared types and width helpers for the approximate-adder error evaluator.
package approx_eval_pkg;

  // Operand width used when no override is given.
  localparam int DEFAULT_WIDTH = 8;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Sum-of-absolute-error accumulator width: error < 2^(w+1) over 2^(2w) pairs.
  function automatic int sae_width(input int w);
    return 3 * w + 1;
  endfunction

  // Error counter width: must hold the full pair count 2^(2w).
  function automatic int count_width(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/approx_adder_err_eval_if.sv
// Bundle of start/done handshake, operand drive, DUT sum return and metric outputs.
interface approx_adder_err_eval_if
  import approx_eval_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                            start;
  logic                            busy;
  logic                            done;
  logic [WIDTH-1:0]                op_a;
  logic [WIDTH-1:0]                op_b;
  logic [WIDTH:0]                  approx_sum;
  logic [sae_width(WIDTH)-1:0]     sae;
  logic [WIDTH:0]                  max_err;
  logic [count_width(WIDTH)-1:0]   err_count;

  // Requester side: issues start, supplies the adder-under-test result, reads metrics.
  modport master (
    output start, approx_sum,
    input  busy, done, op_a, op_b, sae, max_err, err_count
  );

  // Evaluator side.
  modport slave (
    input  start, approx_sum,
    output busy, done, op_a, op_b, sae, max_err, err_count
  );

endinterface

// File: rtl/approx_adder_err_eval_abs_diff.sv
// Unsigned absolute difference; both subtractions are formed and the
// non-negative one selected, so no signed arithmetic or overflow is involved.
module err_abs_diff #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff
);

  logic [WIDTH-1:0] a_minus_b;
  logic [WIDTH-1:0] b_minus_a;

  assign a_minus_b = a - b;
  assign b_minus_a = b - a;
  assign diff      = (a >= b) ? a_minus_b : b_minus_a;

endmodule

// File: rtl/approx_adder_err_eval.sv
// Exhaustive error characterisation of an external approximate adder: sweeps
// every operand pair, registers {approx, exact} and accumulates SAE, worst-case
// error and error count one cycle later.
module approx_adder_err_eval
  import approx_eval_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                   clk,
  input logic                   rst,
  approx_adder_err_eval_if.slave bus
);

  localparam int SAE_W  = sae_width(WIDTH);
  localparam int CNT_W  = count_width(WIDTH);
  localparam int PAIR_W = 2 * WIDTH;

  state_t              state;
  state_t              state_next;
  logic                accept;
  logic                last_pair;
  logic [PAIR_W-1:0]   pair_cnt;
  logic [WIDTH:0]      exact_sum;
  logic                s1_valid;
  logic [WIDTH:0]      s1_approx;
  logic [WIDTH:0]      s1_exact;
  logic [WIDTH:0]      abs_err;
  logic [SAE_W-1:0]    sae_q;
  logic [WIDTH:0]      max_q;
  logic [CNT_W-1:0]    cnt_q;

  // op_b occupies the low half so it sweeps fastest.
  assign bus.op_a  = pair_cnt[PAIR_W-1:WIDTH];
  assign bus.op_b  = pair_cnt[WIDTH-1:0];
  assign exact_sum = {1'b0, pair_cnt[PAIR_W-1:WIDTH]} + {1'b0, pair_cnt[WIDTH-1:0]};
  assign last_pair = &pair_cnt;

  assign bus.busy      = (state == RUN) || (state == DRAIN);
  assign bus.done      = (state == DONE);
  assign bus.sae       = sae_q;
  assign bus.max_err   = max_q;
  assign bus.err_count = cnt_q;

  err_abs_diff #(
    .WIDTH (WIDTH + 1)
  ) u_abs (
    .a    (s1_approx),
    .b    (s1_exact),
    .diff (abs_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only honoured when no sweep is in flight.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_pair) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand counter, capture stage and accumulators; a new run clears results on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_cnt  <= '0;
      s1_valid  <= 1'b0;
      s1_approx <= '0;
      s1_exact  <= '0;
      sae_q     <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
    end else begin
      s1_valid <= (state == RUN);
      if (state == RUN) begin
        s1_approx <= bus.approx_sum;
        s1_exact  <= exact_sum;
        if (!last_pair) begin
          pair_cnt <= pair_cnt + PAIR_W'(1);
        end
      end
      if (accept) begin
        pair_cnt <= '0;
        sae_q    <= '0;
        max_q    <= '0;
        cnt_q    <= '0;
      end else if (s1_valid) begin
        sae_q <= sae_q + SAE_W'(abs_err);
        cnt_q <= cnt_q + CNT_W'(abs_err != '0);
        if (abs_err > max_q) begin
          max_q <= abs_err;
        end
      end
    end
  end

endmodule
